// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction controller:
// FSM state encoding, coin values, product price table and credit sum width.
package vend_pkg;

  localparam int SUM_W = 9;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COLLECT  = 3'd1,
    DISPENSE = 3'd2,
    HOLD     = 3'd3
  } state_e;

  localparam logic [7:0] COIN_5  = 8'd5;
  localparam logic [7:0] COIN_10 = 8'd10;
  localparam logic [7:0] COIN_20 = 8'd20;
  localparam logic [7:0] COIN_50 = 8'd50;

  // Product price table indexed by the 3-bit product select switches.
  function automatic logic [7:0] priceOf(input logic [2:0] sel);
    logic [7:0] p;
    case (sel)
      3'd0:    p = 8'd15;
      3'd1:    p = 8'd20;
      3'd2:    p = 8'd25;
      3'd3:    p = 8'd30;
      3'd4:    p = 8'd45;
      3'd5:    p = 8'd50;
      3'd6:    p = 8'd65;
      default: p = 8'd80;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/vend_txn_controller_if.sv
// Front-end strobes and display/dispense outputs of the vending controller,
// bundled so the bench drives the master side and the controller the slave side.
interface vend_txn_controller_if;
  logic [3:0] coin_pulse;
  logic [2:0] SW;
  logic       confirm;
  logic       cancel;
  logic [7:0] total_money;
  logic [7:0] price;
  logic       dispense;
  logic [7:0] change_amt;
  logic       change_valid;
  logic       coin_reject;
  logic [2:0] state_o;

  modport master (
    output coin_pulse, SW, confirm, cancel,
    input  total_money, price, dispense, change_amt, change_valid, coin_reject, state_o
  );

  modport slave (
    input  coin_pulse, SW, confirm, cancel,
    output total_money, price, dispense, change_amt, change_valid, coin_reject, state_o
  );
endinterface

// File: rtl/vend_txn_controller_coin_decoder.sv
// Priority-encodes the debounced coin strobes into a coin value; the lowest
// set bit wins and any other simultaneous strobes are dropped.
module coin_decoder
  import vend_pkg::*;
(
  input  logic [3:0] coin_pulse_i,
  output logic [7:0] value_o,
  output logic       valid_o
);

  always_comb begin
    value_o = '0;
    valid_o = 1'b0;
    if (coin_pulse_i[0]) begin
      value_o = COIN_5;
      valid_o = 1'b1;
    end else if (coin_pulse_i[1]) begin
      value_o = COIN_10;
      valid_o = 1'b1;
    end else if (coin_pulse_i[2]) begin
      value_o = COIN_20;
      valid_o = 1'b1;
    end else if (coin_pulse_i[3]) begin
      value_o = COIN_50;
      valid_o = 1'b1;
    end
  end

endmodule

// File: rtl/vend_txn_controller.sv
// Vending transaction FSM: owns the credit, latches the price on the first coin,
// dispenses on confirm and shows change or a refund for a fixed hold time.
module vend_txn_controller
  import vend_pkg::*;
#(
  parameter logic [7:0]  MAX_CREDIT     = 8'd250,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000,
  parameter logic [31:0] HOLD_CYCLES    = 32'd200_000_000
) (
  input logic                 CLK100MHZ,
  input logic                 rst,
  vend_txn_controller_if.slave bus
);

  logic [7:0]       coinValue;
  logic             coinValid;
  logic [SUM_W-1:0] sumD;
  logic             coinFits;

  state_e      state_q;
  logic [7:0]  total_q;
  logic [7:0]  price_q;
  logic        dispense_q;
  logic [7:0]  change_q;
  logic        changeValid_q;
  logic        reject_q;
  logic [31:0] count_q;

  coin_decoder u_coin_decoder (
    .coin_pulse_i (bus.coin_pulse),
    .value_o      (coinValue),
    .valid_o      (coinValid)
  );

  // Widened sum so a coin near the ceiling can never wrap past the comparison.
  assign sumD     = {1'b0, total_q} + {1'b0, coinValue};
  assign coinFits = (sumD <= {1'b0, MAX_CREDIT});

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state_q       <= IDLE;
      total_q       <= '0;
      price_q       <= priceOf(bus.SW);
      dispense_q    <= 1'b0;
      change_q      <= '0;
      changeValid_q <= 1'b0;
      reject_q      <= 1'b0;
      count_q       <= '0;
    end else begin
      dispense_q <= 1'b0;
      reject_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          price_q <= priceOf(bus.SW);
          count_q <= '0;
          if (coinValid) begin
            if (coinFits) begin
              total_q <= sumD[7:0];
              state_q <= COLLECT;
            end else begin
              reject_q <= 1'b1;
            end
          end
        end
        COLLECT: begin
          // Cancel outranks everything, and a coin in the same cycle is refused.
          if (bus.cancel) begin
            reject_q      <= coinValid;
            change_q      <= total_q;
            changeValid_q <= 1'b1;
            total_q       <= '0;
            count_q       <= '0;
            state_q       <= HOLD;
          end else if (!coinValid && (count_q == TIMEOUT_CYCLES - 32'd1)) begin
            change_q      <= total_q;
            changeValid_q <= 1'b1;
            total_q       <= '0;
            count_q       <= '0;
            state_q       <= HOLD;
          end else begin
            if (coinValid) begin
              count_q <= '0;
              if (coinFits) total_q <= sumD[7:0];
              else          reject_q <= 1'b1;
            end else begin
              count_q <= count_q + 32'd1;
            end
            // Sufficiency uses the pre-coin credit; a same-cycle coin still lands.
            if (bus.confirm && (total_q >= price_q)) begin
              dispense_q <= 1'b1;
              count_q    <= '0;
              state_q    <= DISPENSE;
            end
          end
        end
        DISPENSE: begin
          reject_q      <= coinValid;
          change_q      <= total_q - price_q;
          changeValid_q <= 1'b1;
          total_q       <= '0;
          count_q       <= '0;
          state_q       <= HOLD;
        end
        HOLD: begin
          reject_q <= coinValid;
          if (count_q == HOLD_CYCLES - 32'd1) begin
            change_q      <= '0;
            changeValid_q <= 1'b0;
            count_q       <= '0;
            state_q       <= IDLE;
          end else begin
            count_q <= count_q + 32'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.total_money  = total_q;
  assign bus.price        = price_q;
  assign bus.dispense     = dispense_q;
  assign bus.change_amt   = change_q;
  assign bus.change_valid = changeValid_q;
  assign bus.coin_reject  = reject_q;
  assign bus.state_o      = state_q;

endmodule

// File: tb/tb_vend_txn_controller.sv
// Self-checking bench for vend_txn_controller: direct checks on credit/price/state
// plus a scoreboard of expected change/refund results compared on each HOLD entry.
module tb_vend_txn_controller;

  localparam logic [31:0] TB_TIMEOUT = 32'd32;
  localparam logic [31:0] TB_HOLD    = 32'd16;

  typedef struct {
    logic       dispensed;
    logic [7:0] change;
  } txn_t;

  logic clk;
  logic rst;
  int   checkCount;
  int   passCount;
  txn_t sbQ[$];
  logic sawDispense;
  logic prevValid;
  logic prevDisp;
  int   n;

  vend_txn_controller_if vif ();

  vend_txn_controller #(
    .MAX_CREDIT     (8'd250),
    .TIMEOUT_CYCLES (TB_TIMEOUT),
    .HOLD_CYCLES    (TB_HOLD)
  ) dut (
    .CLK100MHZ (clk),
    .rst       (rst),
    .bus       (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Drives one cycle of strobes starting at a falling edge; returns at the next one.
  task automatic applyStimulus(input logic [3:0] coin, input logic conf, input logic canc);
    vif.coin_pulse = coin;
    vif.confirm    = conf;
    vif.cancel     = canc;
    @(negedge clk);
    vif.coin_pulse = 4'd0;
    vif.confirm    = 1'b0;
    vif.cancel     = 1'b0;
  endtask

  task automatic waitIdle(output int validCycles);
    validCycles = 0;
    for (int i = 0; i < 400; i++) begin
      if (vif.state_o == 3'd0) break;
      if (vif.change_valid === 1'b1) validCycles++;
      @(negedge clk);
    end
    if (vif.state_o != 3'd0) checkOutput("idleWait", 32'(vif.state_o), 32'd0);
  endtask

  // Scoreboard consumer: every entry into HOLD must match the oldest expectation.
  always @(negedge clk) begin
    txn_t e;
    if (vif.dispense === 1'b1) sawDispense = 1'b1;
    if (vif.dispense === 1'b1 && prevDisp) checkOutput("dispenseWidth", 32'd2, 32'd1);
    if (vif.change_valid === 1'b1 && !prevValid) begin
      if (sbQ.size() == 0) begin
        checkOutput("sbUnderflow", 32'd1, 32'd0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("hold.change", 32'(vif.change_amt), 32'(e.change));
        checkOutput("hold.dispensed", 32'(sawDispense), 32'(e.dispensed));
      end
      sawDispense = 1'b0;
    end
    prevValid = (vif.change_valid === 1'b1);
    prevDisp  = (vif.dispense === 1'b1);
  end

  initial begin
    checkCount     = 0;
    passCount      = 0;
    sawDispense    = 1'b0;
    prevValid      = 1'b0;
    prevDisp       = 1'b0;
    rst            = 1'b1;
    vif.SW         = 3'd2;
    vif.coin_pulse = 4'd0;
    vif.confirm    = 1'b0;
    vif.cancel     = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst.total", 32'(vif.total_money), 32'd0);
    checkOutput("rst.price", 32'(vif.price), 32'd25);
    checkOutput("rst.state", 32'(vif.state_o), 32'd0);
    checkOutput("rst.changeValid", 32'(vif.change_valid), 32'd0);
    checkOutput("rst.change", 32'(vif.change_amt), 32'd0);
    checkOutput("rst.reject", 32'(vif.coin_reject), 32'd0);
    checkOutput("rst.dispense", 32'(vif.dispense), 32'd0);
    rst = 1'b0;

    // Credit accumulation and price freeze
    applyStimulus(4'b0010, 1'b0, 1'b0);
    checkOutput("acc.total10", 32'(vif.total_money), 32'd10);
    checkOutput("acc.state", 32'(vif.state_o), 32'd1);
    applyStimulus(4'b0001, 1'b0, 1'b0);
    checkOutput("acc.total15", 32'(vif.total_money), 32'd15);
    vif.SW = 3'd5;
    @(negedge clk);
    checkOutput("acc.priceFrozen", 32'(vif.price), 32'd25);
    sbQ.push_back('{1'b0, 8'd15});
    applyStimulus(4'b0000, 1'b0, 1'b1);
    checkOutput("cancel.state", 32'(vif.state_o), 32'd3);
    waitIdle(n);
    checkOutput("cancel.holdLen", 32'(n), 32'd16);

    // Purchase with change
    vif.SW = 3'd0;
    @(negedge clk);
    checkOutput("buy.price", 32'(vif.price), 32'd15);
    applyStimulus(4'b0100, 1'b0, 1'b0);
    checkOutput("buy.total", 32'(vif.total_money), 32'd20);
    sbQ.push_back('{1'b1, 8'd5});
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkOutput("buy.stateDisp", 32'(vif.state_o), 32'd2);
    checkOutput("buy.dispense", 32'(vif.dispense), 32'd1);
    @(negedge clk);
    checkOutput("buy.stateHold", 32'(vif.state_o), 32'd3);
    checkOutput("buy.dispenseLow", 32'(vif.dispense), 32'd0);
    checkOutput("buy.totalCleared", 32'(vif.total_money), 32'd0);
    waitIdle(n);
    checkOutput("buy.holdLen", 32'(n), 32'd16);
    checkOutput("buy.idleValid", 32'(vif.change_valid), 32'd0);
    checkOutput("buy.idleChange", 32'(vif.change_amt), 32'd0);

    // Insufficient credit, then enough
    vif.SW = 3'd7;
    @(negedge clk);
    applyStimulus(4'b1000, 1'b0, 1'b0);
    checkOutput("short.price", 32'(vif.price), 32'd80);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkOutput("short.state", 32'(vif.state_o), 32'd1);
    checkOutput("short.dispense", 32'(vif.dispense), 32'd0);
    sbQ.push_back('{1'b1, 8'd20});
    applyStimulus(4'b1000, 1'b0, 1'b0);
    checkOutput("short.total100", 32'(vif.total_money), 32'd100);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkOutput("short.stateDisp", 32'(vif.state_o), 32'd2);
    waitIdle(n);

    // Credit ceiling and multi-bit coin decode
    vif.SW = 3'd0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) applyStimulus(4'b1000, 1'b0, 1'b0);
    applyStimulus(4'b0100, 1'b0, 1'b0);
    applyStimulus(4'b0010, 1'b0, 1'b0);
    checkOutput("ceil.total230", 32'(vif.total_money), 32'd230);
    applyStimulus(4'b1000, 1'b0, 1'b0);
    checkOutput("ceil.reject", 32'(vif.coin_reject), 32'd1);
    checkOutput("ceil.totalKept", 32'(vif.total_money), 32'd230);
    @(negedge clk);
    checkOutput("ceil.rejectPulse", 32'(vif.coin_reject), 32'd0);
    sbQ.push_back('{1'b0, 8'd230});
    applyStimulus(4'b0000, 1'b0, 1'b1);
    waitIdle(n);
    applyStimulus(4'b1010, 1'b0, 1'b0);
    checkOutput("multi.total10", 32'(vif.total_money), 32'd10);
    checkOutput("multi.noReject", 32'(vif.coin_reject), 32'd0);
    sbQ.push_back('{1'b0, 8'd10});
    applyStimulus(4'b0000, 1'b0, 1'b1);
    waitIdle(n);

    // Cancel beats confirm
    applyStimulus(4'b0100, 1'b0, 1'b0);
    applyStimulus(4'b0010, 1'b0, 1'b0);
    applyStimulus(4'b0001, 1'b0, 1'b0);
    checkOutput("both.total35", 32'(vif.total_money), 32'd35);
    sbQ.push_back('{1'b0, 8'd35});
    applyStimulus(4'b0000, 1'b1, 1'b1);
    checkOutput("both.state", 32'(vif.state_o), 32'd3);
    checkOutput("both.dispense", 32'(vif.dispense), 32'd0);
    waitIdle(n);

    // Idle timeout refund
    applyStimulus(4'b0100, 1'b0, 1'b0);
    applyStimulus(4'b0010, 1'b0, 1'b0);
    applyStimulus(4'b0001, 1'b0, 1'b0);
    sbQ.push_back('{1'b0, 8'd35});
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (vif.state_o == 3'd3) break;
      n++;
      @(negedge clk);
    end
    checkOutput("timeout.cycles", 32'(n), 32'd32);
    waitIdle(n);

    // Coin with confirm uses pre-coin credit
    applyStimulus(4'b0010, 1'b0, 1'b0);
    applyStimulus(4'b0001, 1'b1, 1'b0);
    checkOutput("coinConf.total", 32'(vif.total_money), 32'd15);
    checkOutput("coinConf.state", 32'(vif.state_o), 32'd1);
    sbQ.push_back('{1'b1, 8'd0});
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkOutput("coinConf.stateDisp", 32'(vif.state_o), 32'd2);
    waitIdle(n);

    // Coin with cancel is refused and excluded from the refund
    applyStimulus(4'b0001, 1'b0, 1'b0);
    sbQ.push_back('{1'b0, 8'd5});
    applyStimulus(4'b0010, 1'b0, 1'b1);
    checkOutput("coinCancel.reject", 32'(vif.coin_reject), 32'd1);
    waitIdle(n);

    // Coin during HOLD
    applyStimulus(4'b0100, 1'b0, 1'b0);
    sbQ.push_back('{1'b1, 8'd5});
    applyStimulus(4'b0000, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(4'b0001, 1'b0, 1'b0);
    checkOutput("holdCoin.reject", 32'(vif.coin_reject), 32'd1);
    checkOutput("holdCoin.total", 32'(vif.total_money), 32'd0);
    checkOutput("holdCoin.state", 32'(vif.state_o), 32'd3);
    waitIdle(n);

    // Reset mid-transaction forfeits credit
    applyStimulus(4'b0100, 1'b0, 1'b0);
    applyStimulus(4'b0100, 1'b0, 1'b0);
    applyStimulus(4'b0001, 1'b0, 1'b0);
    checkOutput("midRst.total45", 32'(vif.total_money), 32'd45);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midRst.total", 32'(vif.total_money), 32'd0);
    checkOutput("midRst.state", 32'(vif.state_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    checkOutput("sb.empty", 32'(sbQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/vend_txn_controller.md
Name: vend_txn_controller

Overview:
- Sequences one vending transaction: latches the product price, accumulates debounced coin pulses into credit, dispenses on confirm, and computes change or a refund.
- Sits between the button/coin debounce front end and the display/dispense outputs.
- Replaces the free-running credit accumulator with an explicit FSM that owns credit.

Parameters:
- MAX_CREDIT, 8'd250, credit ceiling; a coin that would exceed it is rejected.
- TIMEOUT_CYCLES, 32'd500_000_000, idle cycles in COLLECT before an automatic refund (5 s at 100 MHz).
- HOLD_CYCLES, 32'd200_000_000, cycles that change/refund stays displayed (2 s).

Ports:
- CLK100MHZ  input  1  system clock, 100 MHz
- rst  input  1  synchronous reset, active-high
- coin_pulse  input  4  one-cycle debounced coin strobes: bit0=5, bit1=10, bit2=20, bit3=50
- SW  input  3  product select, 0..7
- confirm  input  1  one-cycle purchase strobe
- cancel  input  1  one-cycle cancel strobe
- total_money  output  8  current credit
- price  output  8  price of latched or selected product
- dispense  output  1  one-cycle pulse; product released
- change_amt  output  8  change or refund amount, valid in HOLD
- change_valid  output  1  high throughout HOLD
- coin_reject  output  1  one-cycle pulse; coin not accepted
- state_o  output  3  FSM state encoding, for debug LEDs

Behaviour:
- Single clock domain. All outputs are registered.
- Reset values: total_money=0, price=PRICE[SW], dispense=0, change_amt=0, change_valid=0, coin_reject=0, state_o=IDLE, timeout counter=0.
- Coin decode: the lowest set bit of coin_pulse wins. Other bits set in the same cycle are dropped silently (no reject). Value is 5/10/20/50.
- Coin acceptance:
  - Accepted only in IDLE or COLLECT.
  - total_money updates on the cycle after the pulse (1-cycle latency).
  - If total_money + value > MAX_CREDIT, credit is unchanged and coin_reject pulses.
  - Any coin arriving in DISPENSE or HOLD is rejected with coin_reject.
  - Arithmetic is 9-bit internally, so the comparison never wraps.
- IDLE:
  - price tracks PRICE[SW] every cycle.
  - An accepted coin latches price, adds the coin value, and moves to COLLECT.
  - confirm and cancel are ignored.
- COLLECT:
  - price is frozen; SW changes are ignored until the next IDLE.
  - Timeout counter clears on any coin and increments otherwise.
  - cancel, or the counter reaching TIMEOUT_CYCLES-1, moves to HOLD with change_amt=total_money (refund); total_money clears.
  - confirm with total_money >= price moves to DISPENSE.
  - confirm with total_money < price is ignored.
- Simultaneous events in COLLECT: cancel beats confirm. Coin plus confirm in the same cycle: the coin is added first and the sufficiency check uses the pre-coin credit for that cycle. Coin plus cancel: the coin is rejected and the refund excludes it.
- DISPENSE (exactly 1 cycle):
  - dispense=1.
  - change_amt = total_money - price.
  - total_money clears.
  - Next state is HOLD.
- HOLD:
  - change_valid=1 and change_amt is held.
  - The counter runs to HOLD_CYCLES-1, then the FSM goes to IDLE and clears change_amt and change_valid.
  - cancel and confirm are ignored.
- Reset mid-transaction: credit is forfeited; all registers return to reset values on the next edge.
- PRICE table: {15,20,25,30,45,50,65,80} for SW=0..7.

Decomposition:
- vend_pkg holds:
  - state localparams: IDLE=0, COLLECT=1, DISPENSE=2, HOLD=3
  - coin value constants
  - the 8-entry PRICE constant table
  - the 9-bit sum width
- One sub-module, coin_decoder: combinational priority encode of coin_pulse to an 8-bit value plus a valid flag.
- The single shared timeout/hold counter lives in the top-level module.

Test Plan:
- Reset; SW=2; pulse coin bit1 then bit0 -> total_money=10 then 15, state COLLECT, price=25. Change SW to 5 -> price stays 25.
- SW=0 (price 15); coins 20; confirm -> dispense pulse 1 cycle, change_amt=5, change_valid for HOLD_CYCLES (bench overrides to 16), then IDLE with total_money=0.
- SW=7 (80); coin 50; confirm -> no dispense, stays COLLECT. Add 50, confirm -> change_amt=20.
- Credit 230; coin 50 -> coin_reject pulse, total_money stays 230. coin_pulse=4'b1010 in IDLE -> only 10 added.
- Credit 35; cancel and confirm in the same cycle -> refund, change_amt=35, no dispense. Separately, no coin for TIMEOUT_CYCLES (bench override 32) -> refund change_amt=35.
- Coin during HOLD -> coin_reject, credit 0. rst asserted in COLLECT with credit 45 -> next cycle total_money=0, state IDLE.
